// File: rtl/tile_switch_pkg.sv
// Shared definitions for the host-to-tile byte switch.
// Header bit positions, FSM states and header-length width.
package tile_switch_pkg;

  localparam int HDR_MARK_BIT  = 7;
  localparam int HDR_READ_BIT  = 6;
  localparam int HDR_DEST_HI   = 5;
  localparam int HDR_DEST_LO   = 4;
  localparam int HDR_BCAST_BIT = 3;
  localparam int HDR_LEN_HI    = 2;
  localparam int HDR_LEN_LO    = 0;
  localparam int HDR_LEN_W     = 3;
  localparam int DEST_W        = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    RD_CAP = 2'd2,
    RD_OUT = 2'd3
  } state_e;

endpackage

// File: rtl/tile_switch.sv
// Host byte stream switch: routes write packets to one or all
// compute tiles and returns single-byte reads from a tile.
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_data/in_valid/in_ready host input stream (header+payload)
//   tile_data_out             per-tile registered byte, 8 bits each
//   tile_data_in              per-tile readback byte, same packing
//   out_data/out_valid/out_ready  readback stream to host
//   err                       one-cycle pulse on dropped byte
//   pkt_cnt                   completed packet count (wrapping)
module tile_switch
  import tile_switch_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int PKT_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [8*NUM_TILES-1:0] tile_data_out,
  input  logic [8*NUM_TILES-1:0] tile_data_in,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err,
  output logic [PKT_CNT_W-1:0]   pkt_cnt
);

  state_e state_q, state_d;

  logic [DEST_W-1:0]    dest_q, dest_d;
  logic                 bcast_q, bcast_d;
  logic [HDR_LEN_W-1:0] len_q, len_d;
  logic [HDR_LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]           out_q, out_d;
  logic                 err_q, err_d;
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;

  logic [NUM_TILES-1:0][7:0] tile_q, tile_d;
  logic [NUM_TILES-1:0][7:0] tin;

  logic acc;

  assign tin           = tile_data_in;
  assign tile_data_out = tile_q;
  assign out_data      = out_q;
  assign err           = err_q;
  assign pkt_cnt       = pkt_q;

  // Handshake flags decode the state register only.
  assign in_ready  = (state_q == IDLE) || (state_q == WRITE);
  assign out_valid = (state_q == RD_OUT);
  assign acc       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    bcast_d = bcast_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = 1'b0;
    pkt_d   = pkt_q;
    tile_d  = tile_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          if (!in_data[HDR_MARK_BIT]) begin
            err_d = 1'b1;
          end else if (in_data[HDR_READ_BIT]) begin
            dest_d  = in_data[HDR_DEST_HI:HDR_DEST_LO];
            state_d = RD_CAP;
          end else begin
            dest_d  = in_data[HDR_DEST_HI:HDR_DEST_LO];
            bcast_d = in_data[HDR_BCAST_BIT];
            len_d   = in_data[HDR_LEN_HI:HDR_LEN_LO];
            cnt_d   = '0;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (acc) begin
          if (bcast_q) begin
            for (int i = 0; i < NUM_TILES; i++) begin
              tile_d[i] = in_data;
            end
          end else begin
            tile_d[dest_q] = in_data;
          end
          cnt_d = cnt_q + 1'b1;
          // len_q holds len-1, so this is the final byte.
          if (cnt_q == len_q) begin
            state_d = IDLE;
            pkt_d   = pkt_q + 1'b1;
          end
        end
      end
      RD_CAP: begin
        out_d   = tin[dest_q];
        state_d = RD_OUT;
      end
      RD_OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          pkt_d   = pkt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      bcast_q <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      pkt_q   <= '0;
      tile_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      bcast_q <= bcast_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
      pkt_q   <= pkt_d;
      tile_q  <= tile_d;
    end
  end

endmodule

// File: tb/tb_tile_switch.sv
// Self-checking bench for tile_switch: directed vectors,
// multi-cycle corner cases and a randomized packet stream.
module tb_tile_switch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] tile_data_out;
  logic [31:0] tile_data_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [7:0]  pkt_cnt;

  tile_switch #(.NUM_TILES(4), .PKT_CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tile_data_out(tile_data_out),
    .tile_data_in (tile_data_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err          (err),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stalls  = 0;

  logic [7:0] m_port [4];
  logic [7:0] m_cnt;

  typedef struct {
    logic [7:0]  hdr;
    logic [7:0]  pay;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  function automatic logic [31:0] m_ports();
    return {m_port[3], m_port[2], m_port[1], m_port[0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) m_port[i] = 8'h00;
    m_cnt = 8'h00;
    chk("rst_ports", tile_data_out, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic wr_pkt(input logic [1:0] d, input bit bc,
                        input int n, input logic [7:0] pay [8],
                        input bit gaps);
    send_byte({1'b1, 1'b0, d, bc, 3'(n - 1)});
    chk("wr_hdr_ports", tile_data_out, m_ports());
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          step();
          chk("wr_gap_hold", tile_data_out, m_ports());
        end
      end
      send_byte(pay[i]);
      if (bc) begin
        for (int t = 0; t < 4; t++) m_port[t] = pay[i];
      end else begin
        m_port[d] = pay[i];
      end
      chk("wr_ports", tile_data_out, m_ports());
    end
    m_cnt = m_cnt + 8'd1;
    chk("wr_pkt_cnt", {24'd0, pkt_cnt}, {24'd0, m_cnt});
  endtask

  task automatic rd_pkt(input logic [1:0] d, input logic [7:0] v,
                        input int stall);
    logic [7:0] tv [4];
    for (int i = 0; i < 4; i++) tv[i] = 8'($urandom);
    tv[d] = v;
    tile_data_in = {tv[3], tv[2], tv[1], tv[0]};
    send_byte({2'b11, d, 4'($urandom)});
    in_valid = 1'b0;
    chk("rd_cap_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rd_cap_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    tile_data_in = 32'($urandom);
    chk("rd_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rd_out_data", {24'd0, out_data}, {24'd0, v});
    chk("rd_out_in_ready", {31'd0, in_ready}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      step();
      chk("rd_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("rd_stall_data", {24'd0, out_data}, {24'd0, v});
      chk("rd_stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    m_cnt = m_cnt + 8'd1;
    chk("rd_done_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_done_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rd_done_hold", {24'd0, out_data}, {24'd0, v});
    chk("rd_pkt_cnt", {24'd0, pkt_cnt}, {24'd0, m_cnt});
    chk("rd_ports", tile_data_out, m_ports());
  endtask

  task automatic junk(input logic [7:0] b);
    send_byte(b);
    in_valid = 1'b0;
    chk("junk_err", {31'd0, err}, 32'd1);
    chk("junk_ports", tile_data_out, m_ports());
    chk("junk_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("junk_err_pulse", {31'd0, err}, 32'd0);
    chk("junk_pkt_cnt", {24'd0, pkt_cnt}, {24'd0, m_cnt});
  endtask

  initial begin
    logic [7:0] pay [8];
    int         ty;

    rst          = 1'b0;
    in_valid     = 1'b0;
    in_data      = 8'h00;
    out_ready    = 1'b0;
    tile_data_in = 32'h0;

    tbl[0] = '{8'h80, 8'h11, 32'h00000011};
    tbl[1] = '{8'h90, 8'h22, 32'h00002211};
    tbl[2] = '{8'hA0, 8'h33, 32'h00332211};
    tbl[3] = '{8'hB0, 8'h44, 32'h44332211};
    tbl[4] = '{8'h98, 8'h5A, 32'h5A5A5A5A};
    tbl[5] = '{8'hA0, 8'hFF, 32'h5AFF5A5A};
    tbl[6] = '{8'h80, 8'h80, 32'h5AFF5A80};

    do_reset();

    // Write to tile1 with two payload bytes.
    send_byte(8'h91);
    chk("w1_hdr", tile_data_out, 32'h0);
    send_byte(8'h05);
    chk("w1_b0", tile_data_out, 32'h00000500);
    send_byte(8'hC3);
    in_valid = 1'b0;
    chk("w1_b1", tile_data_out, 32'h0000C300);
    chk("w1_cnt", {24'd0, pkt_cnt}, 32'd1);
    step();
    chk("w1_hold", tile_data_out, 32'h0000C300);

    // Broadcast one byte.
    send_byte(8'h88);
    send_byte(8'h43);
    in_valid = 1'b0;
    chk("bc_ports", tile_data_out, 32'h43434343);
    chk("bc_cnt", {24'd0, pkt_cnt}, 32'd2);
    m_cnt = 8'd2;
    for (int i = 0; i < 4; i++) m_port[i] = 8'h43;

    // Read tile2 with a three-cycle host stall.
    rd_pkt(2'd2, 8'h0A, 3);

    // Non-header byte in IDLE is dropped.
    junk(8'h12);

    // Table of single-byte writes.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_byte(tbl[i].hdr);
      send_byte(tbl[i].pay);
      chk("tbl_ports", tile_data_out, tbl[i].exp);
      chk("tbl_cnt", {24'd0, pkt_cnt}, 32'(i + 1));
    end
    in_valid = 1'b0;

    // Reset in the middle of a four-byte packet.
    do_reset();
    send_byte(8'h83);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid = 1'b0;
    chk("abort_pre", tile_data_out, 32'h000000BB);
    do_reset();
    chk("abort_cnt", {24'd0, pkt_cnt}, 32'd0);
    pay[0] = 8'h07;
    wr_pkt(2'd0, 1'b0, 1, pay, 1'b0);
    in_valid = 1'b0;
    chk("abort_tile0", tile_data_out, 32'h00000007);

    // Back-to-back packets and counter wrap.
    do_reset();
    stalls = 0;
    for (int p = 0; p < 256; p++) begin
      send_byte(8'hA0);
      send_byte(8'(p));
      if (p == 254)
        chk("wrap_ff", {24'd0, pkt_cnt}, 32'hFF);
    end
    in_valid = 1'b0;
    chk("b2b_stalls", 32'(stalls), 32'd0);
    chk("wrap_00", {24'd0, pkt_cnt}, 32'h00);
    chk("b2b_port2", tile_data_out, 32'h00FF0000);

    // Randomized packet stream.
    do_reset();
    for (int it = 0; it < 150; it++) begin
      ty = $urandom_range(0, 9);
      if (ty <= 5) begin
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        wr_pkt(2'($urandom), 1'($urandom_range(0, 3) == 0),
               $urandom_range(1, 8), pay, 1'($urandom));
      end else if (ty <= 8) begin
        rd_pkt(2'($urandom), 8'($urandom), $urandom_range(0, 3));
      end else begin
        junk({1'b0, 7'($urandom)});
      end
      idle($urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
